uart_loopback_core: RTL and testbench

- 8N1 UART echo path: a receiver deserialises `bit_in` into bytes, a small FIFO buffers them, and a transmitter re-serialises them on `bit_out`.
- Every bit lasts OVERSAMPLE clocks; there is no separate baud enable.
- Sits between the board serial pins and the test logic; used as the loopback / self-test core.

---
 rtl/uart_loopback_core.sv | 218 +++++++++++++++++++++
 tb/tb_uart_loopback_core.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_loopback_core.sv
// 8N1 UART echo path: oversampled receiver, small byte FIFO and a transmitter
// that re-serialises every accepted byte. Each serial bit lasts OVERSAMPLE clocks.
module uart_loopback_core #(
  parameter int M          = 8,
  parameter int OVERSAMPLE = 4,
  parameter int DEPTH      = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         bit_in,
  output logic         bit_out,
  output logic [M-1:0] rx_byte,
  output logic         rx_ready,
  output logic         rx_frame_err,
  output logic [M-1:0] tx_byte,
  output logic         tx_start,
  output logic         tx_busy,
  output logic         fifo_overflow
);

  localparam int CW = $clog2(OVERSAMPLE + 1);
  localparam int BW = $clog2(M + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CW-1:0] HALF = CW'(OVERSAMPLE / 2);
  localparam logic [CW-1:0] FULL = CW'(OVERSAMPLE);
  localparam logic [BW-1:0] LAST = BW'(M - 1);
  localparam logic [AW:0]   CAP  = (AW + 1)'(DEPTH);

  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT} rx_state_t;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;

  rx_state_t      rx_state;
  logic [CW-1:0]  rx_cnt;
  logic [BW-1:0]  rx_idx;
  logic [M-1:0]   rx_shift;

  tx_state_t      tx_state;
  logic [CW-1:0]  tx_cnt;
  logic [BW-1:0]  tx_idx;
  logic [M-1:0]   tx_shift;

  logic [M-1:0]   mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW:0]    count;
  logic           full;
  logic           rd_en;
  logic           wr_en;

  // A read is held off for one cycle after tx_start so the transmitter can raise tx_busy.
  assign full  = (count == CAP);
  assign rd_en = (count != '0) && !tx_busy && !tx_start;
  assign wr_en = rx_ready && (!full || rd_en);

  // Receiver: rx_cnt counts clocks inside the current bit, samples land mid-bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_state     <= RX_IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_shift     <= '0;
      rx_byte      <= '0;
      rx_ready     <= 1'b0;
      rx_frame_err <= 1'b0;
    end else begin
      rx_ready     <= 1'b0;
      rx_frame_err <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!bit_in) begin
            rx_state <= RX_START;
            rx_cnt   <= CW'(1);
          end
        end
        RX_START: begin
          if (rx_cnt == HALF) begin
            rx_state <= bit_in ? RX_IDLE : RX_DATA;
            rx_cnt   <= CW'(1);
            rx_idx   <= '0;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt == FULL) begin
            rx_shift <= {bit_in, rx_shift[M-1:1]};
            rx_cnt   <= CW'(1);
            rx_idx   <= rx_idx + 1'b1;
            if (rx_idx == LAST) begin
              rx_state <= RX_STOP;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (rx_cnt == FULL) begin
            if (bit_in) begin
              rx_byte  <= rx_shift;
              rx_ready <= 1'b1;
              rx_state <= RX_IDLE;
            end else begin
              rx_frame_err <= 1'b1;
              rx_state     <= RX_WAIT;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        RX_WAIT: begin
          if (bit_in) begin
            rx_state <= RX_IDLE;
          end
        end
        default: rx_state <= RX_IDLE;
      endcase
    end
  end

  // FIFO storage has no reset; the pointers and count define its contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= rx_byte;
    end
  end

  // FIFO control, read hand-off to the transmitter and overflow strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      tx_byte       <= '0;
      tx_start      <= 1'b0;
      fifo_overflow <= 1'b0;
    end else begin
      tx_start      <= 1'b0;
      fifo_overflow <= rx_ready && !wr_en;
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        tx_byte  <= mem[rd_ptr];
        tx_start <= 1'b1;
        rd_ptr   <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Transmitter: start bit, M data bits LSB first, one stop bit, OVERSAMPLE clocks each.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= '0;
      tx_idx   <= '0;
      tx_shift <= '0;
      tx_busy  <= 1'b0;
      bit_out  <= 1'b1;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (tx_start) begin
            tx_shift <= tx_byte;
            tx_cnt   <= CW'(1);
            tx_busy  <= 1'b1;
            bit_out  <= 1'b0;
            tx_state <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt == FULL) begin
            bit_out  <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[M-1:1]};
            tx_idx   <= '0;
            tx_cnt   <= CW'(1);
            tx_state <= TX_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt == FULL) begin
            tx_cnt <= CW'(1);
            if (tx_idx == LAST) begin
              bit_out  <= 1'b1;
              tx_state <= TX_STOP;
            end else begin
              bit_out  <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[M-1:1]};
              tx_idx   <= tx_idx + 1'b1;
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (tx_cnt == FULL) begin
            tx_busy  <= 1'b0;
            tx_state <= TX_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: begin
          bit_out  <= 1'b1;
          tx_busy  <= 1'b0;
          tx_state <= TX_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_loopback_core.sv
// Scoreboard bench for uart_loopback_core: two instances (DEPTH 4 and DEPTH 2)
// driven with serial frames; expected bytes, drops and latencies come from a frame-level model.
module tb_uart_loopback_core;

  localparam int OS  = 4;
  // Clocks between two FIFO reads while the transmitter streams: one frame plus the hand-off.
  localparam int TXP = OS * 10 + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]      rst, bi, bo, rr, fe, ts, tbusy, ov;
  logic [1:0][7:0] rb, tb;
  longint          cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  uart_loopback_core #(.M(8), .OVERSAMPLE(OS), .DEPTH(4)) dut0 (
    .clk(clk), .reset(rst[0]), .bit_in(bi[0]), .bit_out(bo[0]),
    .rx_byte(rb[0]), .rx_ready(rr[0]), .rx_frame_err(fe[0]),
    .tx_byte(tb[0]), .tx_start(ts[0]), .tx_busy(tbusy[0]), .fifo_overflow(ov[0]));

  uart_loopback_core #(.M(8), .OVERSAMPLE(OS), .DEPTH(2)) dut1 (
    .clk(clk), .reset(rst[1]), .bit_in(bi[1]), .bit_out(bo[1]),
    .rx_byte(rb[1]), .rx_ready(rr[1]), .rx_frame_err(fe[1]),
    .tx_byte(tb[1]), .tx_start(ts[1]), .tx_busy(tbusy[1]), .fifo_overflow(ov[1]));

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] rxq [2][$];
  logic [7:0] txq [2][$];
  logic [7:0] tsbq [2][$];
  int         dropq [2][$];
  longint     pend [2][$];
  longint     next_rd [2];
  longint     rdyq_ts [$];
  longint     rdyq_bo [$];
  int         depth_of [2] = '{4, 2};
  int         gcnt [2], rcnt [2], err_exp [2], err_seen [2], ov_exp [2], ov_seen [2];
  bit         dec_busy [2];
  bit         main_on = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, expv);
    end
  endtask

  task automatic fail_evt(input string nm);
    vectors++;
    miscompares++;
    $display("FAIL %s: got an unexpected event, expected none", nm);
  endtask

  // Frame-level model: a byte written at edge w is readable from w+1, reads are TXP apart.
  task automatic model_write(input int id, input logic [7:0] d, input longint w);
    longint r;
    bit     rd_now;
    rd_now = 1'b0;
    gcnt[id]++;
    rxq[id].push_back(d);
    while (pend[id].size() > 0) begin
      r = (pend[id][0] + 1 > next_rd[id]) ? pend[id][0] + 1 : next_rd[id];
      if (r < w) begin
        void'(pend[id].pop_front());
        next_rd[id] = r + TXP;
      end else begin
        rd_now = (r == w);
        break;
      end
    end
    if (pend[id].size() >= depth_of[id] && !rd_now) begin
      dropq[id].push_back(gcnt[id]);
      ov_exp[id]++;
    end else begin
      pend[id].push_back(w);
      txq[id].push_back(d);
      tsbq[id].push_back(d);
    end
  endtask

  task automatic drive(input int id, input logic v, input int n);
    bi[id] = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int id, input logic [7:0] d, input logic stop, input int stop_len);
    longint e0;
    e0 = cyc + 1;
    if (stop) model_write(id, d, e0 + OS * 9 + OS / 2 + 1);
    else err_exp[id]++;
    drive(id, 1'b0, OS);
    for (int k = 0; k < 8; k++) drive(id, d[k], OS);
    drive(id, stop, stop_len);
  endtask

  // Reference serial receiver on bit_out: samples mid-bit and checks against the model.
  task automatic decode(input int id);
    longint     n0;
    logic [7:0] d;
    logic       stp, ab;
    forever begin
      @(negedge clk);
      if (bo[id] === 1'b0 && rst[id] === 1'b0) begin
        n0 = cyc; ab = 1'b0; d = 8'h00; stp = 1'b0;
        dec_busy[id] = 1'b1;
        if (id == 0 && main_on) begin
          if (rdyq_bo.size() == 0) fail_evt("bit_out_start");
          else chk("bit_out_latency", n0 - rdyq_bo.pop_front(), 64'd3);
        end
        for (int c = 1; c <= OS * 9 + OS / 2; c++) begin
          @(negedge clk);
          if (rst[id]) ab = 1'b1;
          if (c >= OS + OS / 2 && (c - OS / 2) % OS == 0) begin
            if (c == OS * 9 + OS / 2) stp = bo[id];
            else d[(c - OS / 2) / OS - 1] = bo[id];
          end
        end
        if (!ab) begin
          if (txq[id].size() == 0) fail_evt("tx_serial");
          else chk("tx_serial", {stp, d}, {1'b1, txq[id].pop_front()});
        end
        dec_busy[id] = 1'b0;
      end
    end
  endtask

  // Strobe monitor: pops expectations whenever a DUT presents an output event.
  always @(negedge clk) begin
    for (int id = 0; id < 2; id++) begin
      if (rr[id] === 1'b1) begin
        if (rxq[id].size() == 0) fail_evt("rx_ready");
        else chk("rx_byte", rb[id], rxq[id].pop_front());
        rcnt[id]++;
        if (id == 0 && main_on) begin
          rdyq_ts.push_back(cyc);
          rdyq_bo.push_back(cyc);
        end
      end
      if (fe[id] === 1'b1) err_seen[id]++;
      if (ts[id] === 1'b1) begin
        if (tsbq[id].size() == 0) fail_evt("tx_start");
        else chk("tx_byte", tb[id], tsbq[id].pop_front());
        if (id == 0 && main_on) begin
          if (rdyq_ts.size() == 0) fail_evt("tx_start_timing");
          else chk("tx_start_latency", cyc - rdyq_ts.pop_front(), 64'd2);
        end
      end
      if (ov[id] === 1'b1) begin
        ov_seen[id]++;
        if (dropq[id].size() == 0) fail_evt("fifo_overflow");
        else chk("ovf_frame", rcnt[id], dropq[id].pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit quiet_ok;
    rst = 2'b11;
    bi  = 2'b11;
    fork
      decode(0);
      decode(1);
    join_none
    repeat (3) begin @(posedge clk); #1; end
    rst = 2'b00;
    @(negedge clk);
    for (int id = 0; id < 2; id++)
      chk("reset_state", {bo[id], rb[id], rr[id], fe[id], tb[id], ts[id], tbusy[id], ov[id]},
          {1'b1, 21'h0});
    @(posedge clk); #1;

    fork
      begin
        drive(0, 1'b1, 8 * OS);
        main_on = 1'b1;
        send_frame(0, 8'hA9, 1'b1, OS);
        drive(0, 1'b1, 8 * OS);
        send_frame(0, 8'h95, 1'b1, OS);
        drive(0, 1'b1, 100);
        main_on = 1'b0;
        // One-clock glitch, then a valid frame.
        drive(0, 1'b0, 1);
        drive(0, 1'b1, 2 * OS);
        send_frame(0, 8'hC3, 1'b1, OS);
        drive(0, 1'b1, 2 * OS);
        // Bad stop bit, line back high, then a good frame.
        send_frame(0, 8'h55, 1'b0, OS);
        drive(0, 1'b1, 2 * OS);
        send_frame(0, 8'h3C, 1'b1, OS);
        for (int k = 1; k <= 6; k++) send_frame(0, 8'(k), 1'b1, OS);
        drive(0, 1'b1, 300);
        for (int k = 0; k < 8; k++)
          send_frame(0, 8'($urandom), 1'b1, OS + int'($urandom_range(0, 24)));
        // Reset 20 clocks into an rx frame while the previous byte is being transmitted.
        send_frame(0, 8'($urandom), 1'b1, OS);
        drive(0, 1'b0, OS);
        for (int k = 0; k < 4; k++) drive(0, 1'($urandom), OS);
        rst[0] = 1'b1;
        bi[0]  = 1'b1;
        rxq[0].delete(); txq[0].delete(); tsbq[0].delete(); pend[0].delete();
        next_rd[0] = 0;
        @(posedge clk); #1;
        rst[0] = 1'b0;
        @(negedge clk);
        chk("reset_midframe", {bo[0], rr[0], fe[0], ts[0], tbusy[0], ov[0]}, {1'b1, 5'h0});
        quiet_ok = 1'b1;
        repeat (100) begin
          @(negedge clk);
          if (bo[0] !== 1'b1 || rr[0] !== 1'b0 || fe[0] !== 1'b0 || ts[0] !== 1'b0 || tbusy[0] !== 1'b0)
            quiet_ok = 1'b0;
        end
        chk("post_reset_quiet", quiet_ok, 1'b1);
        @(posedge clk); #1;
        send_frame(0, 8'($urandom), 1'b1, OS);
        drive(0, 1'b1, OS);
      end
      begin
        // Shortened stop bits make the input slightly faster than the echo, forcing drops.
        drive(1, 1'b1, 8 * OS);
        for (int k = 0; k < 60; k++) send_frame(1, 8'($urandom), 1'b1, OS - 1);
        send_frame(1, 8'h5A, 1'b0, OS);
        drive(1, 1'b1, 2 * OS);
      end
    join

    for (int i = 0; i < 6000 && (txq[0].size() > 0 || txq[1].size() > 0 || dec_busy[0] || dec_busy[1]); i++)
      @(negedge clk);
    repeat (10) @(negedge clk);
    for (int id = 0; id < 2; id++) begin
      chk("tx_drain", txq[id].size(), 64'd0);
      chk("rx_drain", rxq[id].size(), 64'd0);
      chk("frame_err_count", err_seen[id], err_exp[id]);
      chk("ovf_count", ov_seen[id], ov_exp[id]);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
